wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone classic-cycle initiator that drives the `ldpcEncDec` Wishbone slave port from a simple valid/ready command interface. It is used in the user area and in the synthesizable bench to load codewords and read results without the management SoC. It issues one single-beat transaction per command, returns read data and status, and aborts hung cycles with a timeout.

## Interface

Parameters:
- `ADDR_W`, 32: Wishbone address width.
- `DATA_W`, 32: Wishbone data width, a multiple of 8.
- `TIMEOUT`, 255: maximum number of cycles `stb` stays high without `ack`. Legal range is 1..65535.

Ports:
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_n_i`  in  1: synchronous, active-low reset.
- `req_valid_i`  in  1: command valid.
- `req_ready_o`  out  1: command accepted when high together with `req_valid_i`.
- `req_we_i`  in  1: 1 = write, 0 = read.
- `req_adr_i`  in  ADDR_W: byte address.
- `req_dat_i`  in  DATA_W: write data.
- `req_sel_i`  in  DATA_W/8: byte enables.
- `rsp_valid_o`  out  1: response valid.
- `rsp_ready_i`  in  1: response consumed when high together with `rsp_valid_o`.
- `rsp_dat_o`  out  DATA_W: read data. It is 0 for writes and for timeouts.
- `rsp_err_o`  out  1: 1 = the transaction timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1: Wishbone master controls.
- `wbm_sel_o`  out  DATA_W/8; `wbm_adr_o`  out  ADDR_W; `wbm_dat_o`  out  DATA_W: Wishbone master fields.
- `wbm_ack_i`  in  1; `wbm_dat_i`  in  DATA_W: slave acknowledge and read data.

## Operation

- **Reset.** While `wb_rst_n_i` is low at a rising edge:
  - the state becomes IDLE;
  - all outputs go to 0, except `req_ready_o`, which goes to 1.
- **Registered outputs.** All outputs are registered.

State machine:
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i & req_ready_o`:
    - latch `we`, `adr`, `dat`, `sel` onto the `wbm_*` outputs;
    - set `cyc` = `stb` = 1;
    - clear the timeout counter;
    - go to BUS.
- **BUS**
  - `req_ready_o` = 0.
  - The `wbm_*` fields are held stable.
  - If `wbm_ack_i` = 1:
    - capture `rsp_dat_o` = `wbm_dat_i` when reading, or 0 when writing;
    - set `rsp_err_o` = 0 and `cyc` = `stb` = 0;
    - set `rsp_valid_o` = 1 and go to RESP.
  - Otherwise, if the counter = TIMEOUT−1:
    - set `cyc` = `stb` = 0, `rsp_err_o` = 1, `rsp_dat_o` = 0;
    - set `rsp_valid_o` = 1 and go to RESP.
  - Otherwise the counter increments.
  - The counter is 16 bits and does not wrap, because TIMEOUT ≤ 65535.
- **RESP**
  - `rsp_valid_o` = 1 and the response fields are held.
  - On `rsp_ready_i`:
    - set `rsp_valid_o` = 0 and `req_ready_o` = 1;
    - go to IDLE.
- **Ordering.** Only one transaction is outstanding. No new command is accepted until the response has been consumed.
- **Stray acks.** `wbm_ack_i` is ignored outside BUS.
- **Ack on the timeout cycle.** If `ack` arrives in the same cycle the counter reaches TIMEOUT−1, `ack` wins and the response is a normal response.
- **Write data.** `wbm_dat_o` is driven with the command data for reads as well. Slaves must ignore it when `we` = 0.
- **Reset mid-operation.** Asserting reset in BUS or RESP drops `cyc`, `stb` and `rsp_valid_o` at that edge. The pending response is discarded.

## Timing

- Command handshake at edge 0 → `cyc` and `stb` high from edge 1.
- A zero-wait slave (combinational `ack` while `stb` is high) → `ack` sampled at edge 2.
- At edge 2:
  - `cyc` and `stb` go low;
  - `rsp_valid_o` goes high.
- A slave with N wait states shifts every later event by N.
- Minimum command-to-response latency is 2 cycles.
- Minimum back-to-back throughput is one transaction per 3 cycles when `rsp_ready_i` is tied high:
  - handshake;
  - bus cycle;
  - response/IDLE.
- Timeout: `stb` is high for exactly TIMEOUT cycles, then `rsp_valid_o` rises at the next edge with `rsp_err_o` = 1.

## Test plan

- **Write, 2 wait states.** Write `adr` 0x3000_0004, `dat` 0xA5A5_0F0F, `sel` 0xF; slave acks in the 3rd `stb` cycle.
  - `stb` is high for 3 cycles with stable fields.
  - `rsp_valid_o` follows with `rsp_dat_o` = 0 and `rsp_err_o` = 0.
- **Zero-wait read.** Read `adr` 0x3000_0010; slave returns 0x1234_5678 with combinational `ack`.
  - `rsp_valid_o` rises 2 cycles after the handshake.
  - `rsp_dat_o` = 0x1234_5678.
- **Timeout.** TIMEOUT = 4; slave never acks.
  - `stb` is high for exactly 4 cycles.
  - Then `rsp_err_o` = 1, `rsp_dat_o` = 0, `cyc` = 0.
- **Ack at the boundary.** TIMEOUT = 4; `ack` arrives in the 4th `stb` cycle with data 0xCAFE_0001.
  - `rsp_err_o` = 0 and `rsp_dat_o` = 0xCAFE_0001.
- **Response backpressure.** Hold `rsp_ready_i` low for 5 cycles with `req_valid_i` continuously high.
  - `rsp_valid_o` and the response data are held.
  - `req_ready_o` stays 0.
  - No new `cyc` is issued until one cycle after `rsp_ready_i` rises.
- **Reset mid-cycle.** Pull `wb_rst_n_i` low during BUS, then during RESP.
  - The next edge gives `cyc` = `stb` = `rsp_valid_o` = 0 and `req_ready_o` = 1.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic single-beat initiator driven by a valid/ready command port.
// One transaction in flight at a time; hung bus cycles end in an error response.
module wb_host_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_adr_i,
  input  logic [DATA_W-1:0]   req_dat_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i
);

  localparam int unsigned SEL_W    = DATA_W / 8;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [15:0]         cnt_q, cnt_d;

  // Next-state and next-output logic for the command/bus/response sequencer
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          we_d        = req_we_i;
          adr_d       = req_adr_i;
          dat_d       = req_dat_i;
          sel_d       = req_sel_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cnt_d       = 16'd0;
          req_ready_d = 1'b0;
          state_d     = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        req_ready_d = 1'b0;
        // ack takes priority over an expiring timeout in the same cycle
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          req_ready_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: vector table of single transactions plus
// hand-written backpressure, reset and stray-ack sequences against a small slave model.
module tb_wb_host_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] sdat_bus;

  int          n_cmp  = 0;
  int          n_fail = 0;

  // slave model: ack in the ack_at-th stb cycle (0 = never), or forced
  int          ack_at;
  logic [31:0] sdat;
  logic        force_ack;
  int          stb_cnt;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] sdat;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_stb;
  } vec_t;

  vec_t vecs[6];

  wb_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_adr_i  (req_adr),
    .req_dat_i  (req_dat),
    .req_sel_i  (req_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wdat),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (sdat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) stb_cnt <= stb ? stb_cnt + 1 : 0;

  assign ack      = force_ack | (stb && (ack_at != 0) && (stb_cnt == ack_at - 1));
  assign sdat_bus = ack ? sdat : 32'h0BAD_0BAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_after_reset(input string nm);
    chk({nm, ".cyc"},       {31'd0, cyc},       32'd0);
    chk({nm, ".stb"},       {31'd0, stb},       32'd0);
    chk({nm, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, ".req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_txn(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    chk({nm, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_we    = v.we;
    req_adr   = v.adr;
    req_dat   = v.dat;
    req_sel   = v.sel;
    ack_at    = v.ack_at;
    sdat      = v.sdat;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_adr   = 32'hFFFF_FFFF;
    req_dat   = 32'hFFFF_FFFF;
    n = 0;
    while (stb && n < 50) begin
      chk({nm, ".cyc"}, {31'd0, cyc}, 32'd1);
      chk({nm, ".we"},  {31'd0, we},  {31'd0, v.we});
      chk({nm, ".adr"}, adr,          v.adr);
      chk({nm, ".wdat"}, wdat,        v.dat);
      chk({nm, ".sel"}, {28'd0, sel}, {28'd0, v.sel});
      n++;
      @(negedge clk);
    end
    chk({nm, ".stb_cycles"}, n, v.exp_stb);
    chk({nm, ".cyc_low"},    {31'd0, cyc},       32'd0);
    chk({nm, ".rsp_valid"},  {31'd0, rsp_valid}, 32'd1);
    chk({nm, ".rsp_err"},    {31'd0, rsp_err},   {31'd0, v.exp_err});
    chk({nm, ".rsp_dat"},    rsp_dat,            v.exp_dat);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"},  {31'd0, rsp_valid}, 32'd0);
    chk({nm, ".ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{we:1'b1, adr:32'h3000_0004, dat:32'hA5A5_0F0F, sel:4'hF, ack_at:3,
                sdat:32'hFFFF_FFFF, exp_dat:32'h0000_0000, exp_err:1'b0, exp_stb:3};
    vecs[1] = '{we:1'b0, adr:32'h3000_0010, dat:32'h1111_2222, sel:4'hF, ack_at:1,
                sdat:32'h1234_5678, exp_dat:32'h1234_5678, exp_err:1'b0, exp_stb:1};
    vecs[2] = '{we:1'b0, adr:32'h3000_0020, dat:32'h0000_0000, sel:4'hF, ack_at:0,
                sdat:32'h7777_7777, exp_dat:32'h0000_0000, exp_err:1'b1, exp_stb:4};
    vecs[3] = '{we:1'b0, adr:32'h3000_0030, dat:32'h0000_0000, sel:4'hF, ack_at:4,
                sdat:32'hCAFE_0001, exp_dat:32'hCAFE_0001, exp_err:1'b0, exp_stb:4};
    vecs[4] = '{we:1'b1, adr:32'h3000_0034, dat:32'hDEAD_BEEF, sel:4'h5, ack_at:0,
                sdat:32'h3333_3333, exp_dat:32'h0000_0000, exp_err:1'b1, exp_stb:4};
    vecs[5] = '{we:1'b0, adr:32'h3000_0038, dat:32'h0000_0000, sel:4'h3, ack_at:2,
                sdat:32'h0000_BEEF, exp_dat:32'h0000_BEEF, exp_err:1'b0, exp_stb:2};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = 32'd0;
    req_dat   = 32'd0;
    req_sel   = 4'd0;
    rsp_ready = 1'b0;
    ack_at    = 0;
    sdat      = 32'd0;
    force_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_after_reset("reset");
    chk("reset.we",      {31'd0, we},      32'd0);
    chk("reset.adr",     adr,              32'd0);
    chk("reset.wdat",    wdat,             32'd0);
    chk("reset.sel",     {28'd0, sel},     32'd0);
    chk("reset.rsp_dat", rsp_dat,          32'd0);
    chk("reset.rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    // stray ack while idle must not produce a response
    force_ack = 1'b1;
    sdat      = 32'h9999_9999;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    chk("stray.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stray.cyc",       {31'd0, cyc},       32'd0);
    chk("stray.rsp_dat",   rsp_dat,            32'd0);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // response backpressure with a new command waiting
    @(negedge clk);
    req_we    = 1'b0;
    req_adr   = 32'h3000_0050;
    req_sel   = 4'hF;
    ack_at    = 1;
    sdat      = 32'h5555_AAAA;
    req_valid = 1'b1;
    @(negedge clk);
    chk("bp.cyc", {31'd0, cyc}, 32'd1);
    @(negedge clk);
    chk("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp.rsp_dat",   rsp_dat,            32'h5555_AAAA);
    sdat = 32'h6666_BBBB;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp.hold_dat",   rsp_dat,            32'h5555_AAAA);
      chk("bp.req_ready",  {31'd0, req_ready}, 32'd0);
      chk("bp.no_cyc",     {31'd0, cyc},       32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.rel_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp.rel_ready", {31'd0, req_ready}, 32'd1);
    chk("bp.rel_cyc",   {31'd0, cyc},       32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.next_cyc", {31'd0, cyc}, 32'd1);
    @(negedge clk);
    chk("bp.next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp.next_dat",   rsp_dat,            32'h6666_BBBB);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // reset while in BUS
    req_adr   = 32'h3000_0060;
    ack_at    = 0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstbus.stb_before", {31'd0, stb}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_after_reset("rstbus");

    // reset while in RESP
    ack_at    = 1;
    sdat      = 32'h4444_4444;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstresp.valid_before", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_after_reset("rstresp");
    chk("rstresp.rsp_dat", rsp_dat, 32'd0);

    do_txn('{we:1'b0, adr:32'h3000_0070, dat:32'h0000_0000, sel:4'hF, ack_at:2,
             sdat:32'h0F0F_1234, exp_dat:32'h0F0F_1234, exp_err:1'b0, exp_stb:2}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
